axis_upsize_rr_arbiter: RTL
===========================

Name: axis_upsize_rr_arbiter

Overview:
- Packet-level round-robin arbiter that shares one AXI-stream width upsizer (WIDTH in, 2*WIDTH out) between NUM_SRC narrow AXI-stream sources.
- Grants one source at a time and holds the grant until that source's tlast beat is accepted.
- Drives the upsizer's slave port through a single registered output stage.
- Reports the granted source index on m_axis_tid so downstream logic can steer the widened packet.

Parameters:
- NUM_SRC, 4, number of requesting slave streams (2..16).
- WIDTH, 32, data width of each slave stream and of the master (upsizer input) stream.
- ID_W, 2, width of m_axis_tid; must satisfy 2**ID_W >= NUM_SRC.

Ports:
- aclk  in  1  clock, all logic rising-edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tready  out  NUM_SRC  per-source ready.
- s_axis_tdata  in  NUM_SRC*WIDTH  per-source data; source i occupies bits [i*WIDTH +: WIDTH].
- s_axis_tlast  in  NUM_SRC  per-source end of packet.
- m_axis_tvalid  out  1  valid toward the upsizer.
- m_axis_tready  in  1  ready from the upsizer.
- m_axis_tdata  out  WIDTH  data toward the upsizer.
- m_axis_tlast  out  1  end of packet toward the upsizer.
- m_axis_tid  out  ID_W  index of the source that produced the current output beat.
- busy  out  1  high while a grant is held (LOCKED state).

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant=0, last_grant=NUM_SRC-1, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tid=0, busy=0, s_axis_tready=0.
- Reset mid-packet: in-flight beat is discarded, the grant is dropped, and the pointer returns to its reset value. No partial-packet recovery.
- IDLE state:
  - All s_axis_tready=0.
  - If any s_axis_tvalid is high, grant = first valid source searching (last_grant+1) mod NUM_SRC upward with wrap. Go to LOCKED next cycle and set busy=1.
  - 1-cycle arbitration latency: no data is accepted in the decision cycle.
- LOCKED state:
  - s_axis_tready[grant] = (!m_axis_tvalid || m_axis_tready). All other s_axis_tready=0.
  - Slave accept (tvalid&&tready on the granted source) loads the output register with data, tlast, and tid=grant; m_axis_tvalid=1 next cycle.
  - Output register: m_axis_tvalid clears after an output handshake unless a new beat is loaded in the same cycle. Full throughput is 1 beat/cycle while m_axis_tready stays high.
  - Output is held stable (tdata/tlast/tid) while tvalid=1 and tready=0, as AXI-stream requires.
  - Accepting the granted source's tlast beat sets state=IDLE, last_grant=grant, busy=0 next cycle. The output register still drains normally.
- Gap between packets: at least one IDLE cycle on the slave side. With m_axis_tready=1 the master sees one bubble cycle between back-to-back packets.
- Fairness: a source that is continuously valid is granted within NUM_SRC packet slots.
- A source dropping tvalid mid-packet keeps its grant. There is no timeout.
- Single-beat packet (tvalid and tlast on the first beat): LOCKED lasts one accept cycle.
- Simultaneous events:
  - In IDLE, requests from all sources resolve by the pointer alone.
  - A tlast accept and an output handshake in the same cycle are both honoured.
- Ungranted sources see tready=0 regardless of their tvalid or tlast.
- m_axis_tid is zero-extended when ID_W exceeds the index width.

Test Plan:
- Single source: source 0 sends 4 beats 0x100..0x103, tlast on beat 3, m_axis_tready=1.
  -> Output appears 2 cycles after s_axis_tvalid rises, 1 beat/cycle, tid=0, tlast on 0x103. After the upsizer: 64-bit words 0x00000101_00000100 and 0x00000103_00000102.
- All 4 sources valid continuously, 2-beat packets.
  -> Grant order 0,1,2,3,0,… with tid matching. Exactly one IDLE bubble between packets. No interleaving of beats from different sources.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 6-beat packet from source 2.
  -> Output data is stable during stalls, s_axis_tready[2] is low whenever the register is full and stalled, no beats are lost or duplicated.
- Pointer fairness: source 1 finishes a packet while sources 0 and 3 request.
  -> Next grant = 3, then 0.
- Source 1 deasserts tvalid for 3 cycles mid-packet while source 0 requests.
  -> Grant stays on 1, source 0 tready stays 0, and source 0 is granted only after source 1's tlast.
- areset pulsed during beat 2 of a source 3 packet.
  -> Outputs are zero at once. After release, with sources 0 and 3 valid, the first grant = 0.

Source files
------------

// File: rtl/axis_upsize_rr_arbiter.sv
// Packet-level round-robin arbiter feeding one shared AXI-stream upsizer.
// One registered output stage; the grant is held until the granted source's tlast beat is accepted.
module axis_upsize_rr_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ID_W    = 2
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [NUM_SRC-1:0]         s_axis_tvalid,
    output logic [NUM_SRC-1:0]         s_axis_tready,
    input  logic [NUM_SRC*WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_SRC-1:0]         s_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [WIDTH-1:0]           m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic [ID_W-1:0]            m_axis_tid,
    output logic                       busy
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_last_grant;
    logic               r_busy;
    logic               r_m_tvalid;
    logic               r_m_tlast;
    logic [WIDTH-1:0]   r_m_tdata;
    logic [ID_W-1:0]    r_m_tid;

    logic               w_out_free;
    logic               w_accept;
    logic               w_any_req;
    logic [IDX_W-1:0]   w_next_grant;
    int unsigned        w_idx;
    logic [WIDTH-1:0]   w_sel_data;

    // Search starts just past the previous winner and wraps, giving each source a turn.
    always_comb begin
        w_any_req    = 1'b0;
        w_next_grant = '0;
        w_idx        = 0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            w_idx = (32'(r_last_grant) + k) % NUM_SRC;
            if (!w_any_req && s_axis_tvalid[IDX_W'(w_idx)]) begin
                w_any_req    = 1'b1;
                w_next_grant = IDX_W'(w_idx);
            end
        end
    end

    assign w_out_free = !r_m_tvalid || m_axis_tready;
    assign w_accept   = (r_state == ST_LOCKED) && s_axis_tvalid[r_grant] && w_out_free;
    assign w_sel_data = s_axis_tdata[r_grant*WIDTH +: WIDTH];

    always_comb begin
        s_axis_tready = '0;
        if (r_state == ST_LOCKED) begin
            s_axis_tready[r_grant] = w_out_free;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= IDX_W'(NUM_SRC - 1);
            r_busy       <= 1'b0;
            r_m_tvalid   <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tid      <= '0;
        end else begin
            // A load in the same cycle as an output handshake keeps tvalid high.
            if (w_accept) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= w_sel_data;
                r_m_tlast  <= s_axis_tlast[r_grant];
                r_m_tid    <= ID_W'(r_grant);
            end else if (m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_next_grant;
                        r_state <= ST_LOCKED;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (w_accept && s_axis_tlast[r_grant]) begin
                        r_state      <= ST_IDLE;
                        r_last_grant <= r_grant;
                        r_busy       <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tid    = r_m_tid;
    assign busy          = r_busy;

endmodule
